// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between the I-cache refill port and the D-cache port.
// Data-first priority with I anti-starvation, response timeout and flushed-fetch draining.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_bus,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_resp,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_rd_req,
  input  logic                  d_wr_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  bus_error,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            owner
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] T_LAST     = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0]    OWN_NONE   = 2'd0;
  localparam logic [1:0]    OWN_I      = 2'd1;
  localparam logic [1:0]    OWN_D      = 2'd2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

  state_t          r_state;
  logic [SW-1:0]   r_streak;
  logic [TW-1:0]   r_tcnt;

  logic w_d_pend, w_i_pend, w_grant_d, w_grant_i, w_tmo;

  assign w_d_pend  = d_rd_req | d_wr_req;
  assign w_i_pend  = i_req & ~flush_bus;
  assign w_grant_d = w_d_pend & (~w_i_pend | (r_streak != STREAK_MAX));
  assign w_grant_i = w_i_pend & ~w_grant_d;
  assign w_tmo     = (TIMEOUT_CYCLES > 0) && (r_tcnt == T_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_streak   <= '0;
      r_tcnt     <= '0;
      i_resp     <= 1'b0;
      i_rdata    <= '0;
      d_resp     <= 1'b0;
      d_rdata    <= '0;
      bus_error  <= 1'b0;
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= OWN_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          r_tcnt <= '0;
          if (w_grant_d) begin
            // Write wins if both directions are raised together
            mem_wr_req <= d_wr_req;
            mem_rd_req <= ~d_wr_req;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            owner      <= OWN_D;
            r_streak   <= w_i_pend ? r_streak + 1'b1 : '0;
            r_state    <= BUSY;
          end else if (w_grant_i) begin
            mem_rd_req <= 1'b1;
            mem_wr_req <= 1'b0;
            mem_addr   <= i_addr;
            owner      <= OWN_I;
            r_streak   <= '0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (TIMEOUT_CYCLES > 0) r_tcnt <= r_tcnt + 1'b1;
          if (mem_resp) begin
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            if (owner == OWN_D) begin
              d_resp  <= 1'b1;
              d_rdata <= mem_rdata;
            end else if (!flush_bus) begin
              i_resp  <= 1'b1;
              i_rdata <= mem_rdata;
            end
            r_state <= RESP;
          end else if (flush_bus && owner == OWN_I) begin
            if (w_tmo) begin
              mem_rd_req <= 1'b0;
              owner      <= OWN_NONE;
              r_state    <= IDLE;
            end else begin
              r_state <= DRAIN;
            end
          end else if (w_tmo) begin
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            bus_error  <= 1'b1;
            if (owner == OWN_D) begin
              d_resp  <= 1'b1;
              d_rdata <= '0;
            end else begin
              i_resp  <= 1'b1;
              i_rdata <= '0;
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          i_resp    <= 1'b0;
          d_resp    <= 1'b0;
          bus_error <= 1'b0;
          owner     <= OWN_NONE;
          r_state   <= IDLE;
        end
        DRAIN: begin
          // Flushed fetch: let memory finish, then release silently
          if (TIMEOUT_CYCLES > 0) r_tcnt <= r_tcnt + 1'b1;
          if (mem_resp || w_tmo) begin
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            owner      <= OWN_NONE;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, streak limit, timeout, flush drain, reset.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush_bus, i_req, d_rd_req, d_wr_req, mem_resp;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_resp, d_resp, bus_error, mem_rd_req, mem_wr_req;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_D_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .flush_bus(flush_bus),
    .i_req(i_req), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata), .bus_error(bus_error),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_bus = 0; i_req = 0; d_rd_req = 0; d_wr_req = 0; mem_resp = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    tick(); tick();
    checks++;
    if ({i_resp, d_resp, bus_error, mem_rd_req, mem_wr_req, owner} !== 7'd0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {i_resp, d_resp, bus_error, mem_rd_req, mem_wr_req, owner});
    end
    checks++;
    if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'd0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {i_rdata, d_rdata, mem_addr, mem_wdata});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_i_read();
    i_req = 1; i_addr = 32'h100;
    tick();
    checks++;
    if (mem_rd_req !== 1'b1 || mem_addr !== 32'h100 || owner !== 2'd1) begin
      errors++; $display("FAIL i_read_grant got rd=%b addr=%h own=%0d exp rd=1 addr=100 own=1", mem_rd_req, mem_addr, owner);
    end
    tick(); tick();
    mem_resp = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    checks++;
    if (i_resp !== 1'b1 || i_rdata !== 32'hDEADBEEF || bus_error !== 1'b0 || mem_rd_req !== 1'b0) begin
      errors++; $display("FAIL i_read_resp got resp=%b data=%h err=%b rd=%b exp 1 deadbeef 0 0", i_resp, i_rdata, bus_error, mem_rd_req);
    end
    mem_resp = 0; i_req = 0;
    tick();
    checks++;
    if (i_resp !== 1'b0 || owner !== 2'd0) begin
      errors++; $display("FAIL i_read_done got resp=%b own=%0d exp 0 0", i_resp, owner);
    end
  endtask

  task automatic test_d_write();
    // Both directions raised: write must win
    d_wr_req = 1; d_rd_req = 1; d_addr = 32'h2000; d_wdata = 32'h12345678;
    tick();
    checks++;
    if (mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0 || mem_addr !== 32'h2000 || mem_wdata !== 32'h12345678 || owner !== 2'd2) begin
      errors++; $display("FAIL d_write_grant got wr=%b rd=%b addr=%h wd=%h own=%0d", mem_wr_req, mem_rd_req, mem_addr, mem_wdata, owner);
    end
    d_rd_req = 0; d_addr = 32'hFFFF; d_wdata = 32'h0;
    tick(); tick();
    checks++;
    if (mem_wr_req !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'h12345678 || d_resp !== 1'b0) begin
      errors++; $display("FAIL d_write_stable got wr=%b addr=%h wd=%h resp=%b", mem_wr_req, mem_addr, mem_wdata, d_resp);
    end
    mem_resp = 1; mem_rdata = 32'h0;
    tick();
    checks++;
    if (d_resp !== 1'b1 || mem_wr_req !== 1'b0 || i_resp !== 1'b0) begin
      errors++; $display("FAIL d_write_resp got dresp=%b wr=%b iresp=%b exp 1 0 0", d_resp, mem_wr_req, i_resp);
    end
    mem_resp = 0; d_wr_req = 0;
    tick(); tick();
    checks++;
    if (d_resp !== 1'b0 || owner !== 2'd0 || mem_wr_req !== 1'b0) begin
      errors++; $display("FAIL d_write_once got dresp=%b own=%0d wr=%b exp 0 0 0", d_resp, owner, mem_wr_req);
    end
  endtask

  task automatic test_streak();
    logic [1:0] exp_own [7] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2};
    int dcnt;
    dcnt = 6; i_req = 1; i_addr = 32'h300; d_rd_req = 1; d_addr = 32'h4000;
    for (int g = 0; g < 7; g++) begin
      tick();
      checks++;
      if (owner !== exp_own[g] || mem_rd_req !== 1'b1) begin
        errors++; $display("FAIL streak_grant%0d got own=%0d rd=%b exp own=%0d rd=1", g, owner, mem_rd_req, exp_own[g]);
      end
      mem_resp = 1; mem_rdata = 32'hA000_0000 + g;
      tick();
      checks++;
      if ((exp_own[g] == 2'd1) ? (i_resp !== 1'b1 || d_resp !== 1'b0) : (d_resp !== 1'b1 || i_resp !== 1'b0)) begin
        errors++; $display("FAIL streak_resp%0d got i=%b d=%b exp owner %0d", g, i_resp, d_resp, exp_own[g]);
      end
      mem_resp = 0;
      if (exp_own[g] == 2'd1) i_req = 0;
      else begin
        dcnt--;
        if (dcnt == 0) d_rd_req = 0;
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    d_rd_req = 1; d_addr = 32'h3000;
    tick();
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (mem_rd_req !== 1'b1 || d_resp !== 1'b0) begin
      errors++; $display("FAIL tmo_held got rd=%b resp=%b exp 1 0", mem_rd_req, d_resp);
    end
    tick();
    checks++;
    if (mem_rd_req !== 1'b0 || d_resp !== 1'b1 || bus_error !== 1'b1 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL tmo_fire got rd=%b resp=%b err=%b data=%h exp 0 1 1 0", mem_rd_req, d_resp, bus_error, d_rdata);
    end
    d_rd_req = 0;
    tick();
    checks++;
    if (d_resp !== 1'b0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL tmo_pulse got resp=%b err=%b exp 0 0", d_resp, bus_error);
    end
    tick(); tick(); tick();
    mem_resp = 1; mem_rdata = 32'h5555_5555;
    tick();
    mem_resp = 0;
    checks++;
    if (d_resp !== 1'b0 || i_resp !== 1'b0 || owner !== 2'd0 || mem_rd_req !== 1'b0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL tmo_late got d=%b i=%b own=%0d rd=%b data=%h", d_resp, i_resp, owner, mem_rd_req, d_rdata);
    end
    tick();
  endtask

  task automatic test_flush_drain();
    i_req = 1; i_addr = 32'h400;
    tick(); tick();
    flush_bus = 1;
    tick();
    flush_bus = 0; i_req = 0;
    d_wr_req = 1; d_addr = 32'h500; d_wdata = 32'h55;
    checks++;
    if (mem_rd_req !== 1'b1 || owner !== 2'd1) begin
      errors++; $display("FAIL drain_hold got rd=%b own=%0d exp 1 1", mem_rd_req, owner);
    end
    tick(); tick();
    checks++;
    if (mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0 || owner !== 2'd1 || i_resp !== 1'b0) begin
      errors++; $display("FAIL drain_wait got rd=%b wr=%b own=%0d iresp=%b", mem_rd_req, mem_wr_req, owner, i_resp);
    end
    mem_resp = 1; mem_rdata = 32'hBAD;
    tick();
    mem_resp = 0;
    checks++;
    if (i_resp !== 1'b0 || mem_rd_req !== 1'b0 || i_rdata !== 32'hA000_0004) begin
      errors++; $display("FAIL drain_end got iresp=%b rd=%b idata=%h exp 0 0 a0000004", i_resp, mem_rd_req, i_rdata);
    end
    tick();
    checks++;
    if (owner !== 2'd2 || mem_wr_req !== 1'b1 || mem_addr !== 32'h500 || mem_wdata !== 32'h55) begin
      errors++; $display("FAIL drain_next_d got own=%0d wr=%b addr=%h wd=%h", owner, mem_wr_req, mem_addr, mem_wdata);
    end
    mem_resp = 1; mem_rdata = 32'h77;
    tick();
    mem_resp = 0; d_wr_req = 0;
    checks++;
    if (d_resp !== 1'b1 || d_rdata !== 32'h77) begin
      errors++; $display("FAIL drain_d_resp got resp=%b data=%h exp 1 77", d_resp, d_rdata);
    end
    tick(); tick();
  endtask

  task automatic test_flush_with_resp();
    i_req = 1; i_addr = 32'h600;
    tick(); tick();
    flush_bus = 1; mem_resp = 1; mem_rdata = 32'hCAFE;
    tick();
    flush_bus = 0; mem_resp = 0; i_req = 0;
    checks++;
    if (i_resp !== 1'b0 || mem_rd_req !== 1'b0 || i_rdata !== 32'hA000_0004) begin
      errors++; $display("FAIL flush_resp got iresp=%b rd=%b idata=%h exp 0 0 a0000004", i_resp, mem_rd_req, i_rdata);
    end
    tick(); tick();
    checks++;
    if (owner !== 2'd0 || i_resp !== 1'b0) begin
      errors++; $display("FAIL flush_resp_idle got own=%0d iresp=%b exp 0 0", owner, i_resp);
    end
  endtask

  task automatic test_reset_busy();
    d_rd_req = 1; d_addr = 32'h700;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0; d_rd_req = 0;
    checks++;
    if ({i_resp, d_resp, bus_error, mem_rd_req, mem_wr_req, owner} !== 7'd0 ||
        {i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'd0) begin
      errors++; $display("FAIL reset_busy got ctrl=%b dr=%h ma=%h", {i_resp, d_resp, bus_error, mem_rd_req, mem_wr_req, owner}, d_rdata, mem_addr);
    end
    mem_resp = 1; mem_rdata = 32'h99;
    tick();
    mem_resp = 0;
    checks++;
    if (d_resp !== 1'b0 || i_resp !== 1'b0 || owner !== 2'd0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_no_resp got d=%b i=%b own=%0d data=%h", d_resp, i_resp, owner, d_rdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_streak();
    test_timeout();
    test_flush_drain();
    test_flush_with_resp();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
